cec_frame_scheduler: RTL and testbench

Frame-level controller for the CEC byte transmitter. It arbitrates between two requesters and builds each frame: a header byte followed by 0–15 operand bytes. It feeds the transmitter one byte at a time, enforces CEC signal-free time, checks every byte's acknowledge, and retransmits a failed frame. It sits between the application command sources (e.g. boot announcement, user command) and the CEC line driver.

---
 rtl/cec_pkg.sv | 24 ++
 rtl/cec_free_timer.sv | 54 +++++
 rtl/cec_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_cec_frame_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cec_pkg.sv
// Shared types and constants for the CEC frame scheduler.
// Free-time multipliers are expressed in nominal data bit periods.
package cec_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARB,
      S_WAIT_FREE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_BYTE,
      S_CHECK,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [3:0] CEC_BROADCAST_ADDR = 4'hF;

   localparam int FREE_RETRY = 3;
   localparam int FREE_NEW   = 5;
   localparam int FREE_SAME  = 7;

endpackage

// File: rtl/cec_free_timer.sv
// Saturating CEC signal-free-time counter and threshold compare.
// CEC_RETRY_EN adds the shorter retransmission threshold.
module cec_free_timer
   import cec_pkg::*;
#(
   parameter int BIT_CYCLES = 64800
) (
   input  logic clk,
   input  logic rst,
   input  logic cec_line,
`ifdef CEC_RETRY_EN
   input  logic retry,
`endif
   input  logic same,
   output logic free_ok
);

   localparam int CW = $clog2(FREE_SAME * BIT_CYCLES + 1);
   localparam logic [CW-1:0] T_SAME = CW'(FREE_SAME * BIT_CYCLES);
   localparam logic [CW-1:0] T_NEW  = CW'(FREE_NEW * BIT_CYCLES);
`ifdef CEC_RETRY_EN
   localparam logic [CW-1:0] T_RETRY = CW'(FREE_RETRY * BIT_CYCLES);
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] thr;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (!cec_line) begin
         cnt_d = '0;
      end else if (cnt_q != T_SAME) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_comb begin
      thr = same ? T_SAME : T_NEW;
`ifdef CEC_RETRY_EN
      if (retry) thr = T_RETRY;
`endif
   end

   assign free_ok = (cnt_q >= thr);

   // Out of reset the bus is treated as having been free forever.
   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= T_SAME;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cec_frame_scheduler.sv
// Two-requester CEC frame builder: arbitration, free-time, per-byte ack, retransmission.
// Define CEC_RETRY_EN to enable retransmission of NACKed frames (up to MAX_RETRY).
module cec_frame_scheduler
   import cec_pkg::*;
#(
   parameter logic [3:0] LOGICAL_ADDR = 4'h4,
   parameter int         BIT_CYCLES   = 64800,
   parameter int         MAX_RETRY    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   input  logic [1:0][3:0] req_dest,
   input  logic [1:0][3:0] req_len,
   output logic [3:0]      rd_idx,
   input  logic [1:0][7:0] req_rd_data,
   output logic [1:0]      done,
   output logic [1:0]      fail,
   output logic            busy,
   input  logic            cec_line,
   input  logic            tx_idle,
   input  logic            tx_byte_acknowledged,
   output logic            tx_data_ready,
   output logic [7:0]      tx_data_out,
   output logic            tx_data_eom,
   output logic            tx_data_broadcast
);

   if (MAX_RETRY < 0 || MAX_RETRY > 6) begin : g_bad_max_retry
      $error("MAX_RETRY must fit the 3-bit retry counter (0..6)");
   end

   state_t     state_q, state_d;
   logic       grant_q, grant_d;
   logic       ptr_q, ptr_d;
   logic [3:0] dest_q, dest_d;
   logic [3:0] len_q, len_d;
   logic [3:0] n_q, n_d;
   logic       ack_q, ack_d;
   logic       last_ours_q, last_ours_d;
   logic [7:0] data_q, data_d;
   logic       eom_q, eom_d;
   logic       bcast_q, bcast_d;
   logic       arb_win;
   logic       free_ok;
`ifdef CEC_RETRY_EN
   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
   logic [2:0] retry_q, retry_d;
`endif

   cec_free_timer #(.BIT_CYCLES(BIT_CYCLES)) u_free_timer (
      .clk      (clk),
      .rst      (rst),
      .cec_line (cec_line),
`ifdef CEC_RETRY_EN
      .retry    (retry_q != 3'd0),
`endif
      .same     (last_ours_q),
      .free_ok  (free_ok)
   );

   assign arb_win = req_valid[ptr_q] ? ptr_q : ~ptr_q;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      dest_d        = dest_q;
      len_d         = len_q;
      n_d           = n_q;
      ack_d         = ack_q;
      last_ours_d   = last_ours_q;
      data_d        = data_q;
      eom_d         = eom_q;
      bcast_d       = bcast_q;
`ifdef CEC_RETRY_EN
      retry_d       = retry_q;
`endif
      done          = 2'b00;
      fail          = 2'b00;
      tx_data_ready = 1'b0;

      unique case (state_q)
         S_IDLE: if (|req_valid) state_d = S_ARB;
         S_ARB: begin
            if (|req_valid) begin
               grant_d = arb_win;
               dest_d  = req_dest[arb_win];
               len_d   = req_len[arb_win];
               bcast_d = (req_dest[arb_win] == CEC_BROADCAST_ADDR);
               n_d     = 4'd0;
`ifdef CEC_RETRY_EN
               retry_d = 3'd0;
`endif
               state_d = S_WAIT_FREE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_FREE: if (free_ok) state_d = S_LOAD;
         S_LOAD: begin
            data_d  = (n_q == 4'd0) ? {LOGICAL_ADDR, dest_q} : req_rd_data[grant_q];
            eom_d   = (n_q == len_q);
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (tx_idle) begin
               tx_data_ready = 1'b1;
               state_d       = S_WAIT_START;
            end
         end
         S_WAIT_START: begin
            ack_d = 1'b0;
            if (!tx_idle) state_d = S_WAIT_BYTE;
         end
         S_WAIT_BYTE: begin
            if (tx_byte_acknowledged) ack_d = 1'b1;
            if (tx_idle) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (ack_q) begin
               if (n_q == len_q) begin
                  state_d = S_DONE;
               end else begin
                  n_d     = n_q + 4'd1;
                  state_d = S_LOAD;
               end
            end else begin
`ifdef CEC_RETRY_EN
               retry_d = retry_q + 3'd1;
               if ({1'b0, retry_q} + 4'd1 <= RETRY_LIMIT) begin
                  n_d     = 4'd0;
                  state_d = S_WAIT_FREE;
               end else begin
                  state_d = S_FAIL;
               end
`else
               state_d = S_FAIL;
`endif
            end
         end
         S_DONE: begin
            done[grant_q] = 1'b1;
            last_ours_d   = 1'b1;
            ptr_d         = ~grant_q;
            state_d       = S_IDLE;
         end
         S_FAIL: begin
            fail[grant_q] = 1'b1;
            last_ours_d   = 1'b0;
            ptr_d         = ~grant_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b0;
         ptr_q       <= 1'b0;
         dest_q      <= 4'd0;
         len_q       <= 4'd0;
         n_q         <= 4'd0;
         ack_q       <= 1'b0;
         last_ours_q <= 1'b0;
         data_q      <= 8'd0;
         eom_q       <= 1'b0;
         bcast_q     <= 1'b0;
`ifdef CEC_RETRY_EN
         retry_q     <= 3'd0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         dest_q      <= dest_d;
         len_q       <= len_d;
         n_q         <= n_d;
         ack_q       <= ack_d;
         last_ours_q <= last_ours_d;
         data_q      <= data_d;
         eom_q       <= eom_d;
         bcast_q     <= bcast_d;
`ifdef CEC_RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   // Operand n is fetched from requester slot n-1; the header needs no fetch.
   assign rd_idx            = (n_q == 4'd0) ? 4'd0 : n_q - 4'd1;
   assign busy              = (state_q != S_IDLE);
   assign tx_data_out       = data_q;
   assign tx_data_eom       = eom_q;
   assign tx_data_broadcast = bcast_q;

endmodule

// File: tb/tb_cec_frame_scheduler.sv
// Self-checking bench: table of frames against a byte scoreboard plus a behavioural transmitter.
module tb_cec_frame_scheduler;

   localparam int BITC      = 100;
   localparam int MAX_RETRY = 5;

   typedef struct {
      logic [7:0] data;
      logic       eom;
      logic       bcast;
      bit         hdr;
      int         min_free;
   } exp_byte_t;

   typedef struct {
      int rq;
      bit ok;
   } outcome_t;

   typedef struct {
      int         rq;
      logic [3:0] dest;
      logic [3:0] len;
      int         nack_byte;
      int         nacks;
   } frame_vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0][3:0] req_dest;
   logic [1:0][3:0] req_len;
   logic [3:0]      rd_idx;
   logic [1:0][7:0] req_rd_data;
   logic [1:0]      done, fail;
   logic            busy;
   logic            cec_line, tx_idle, tx_byte_acknowledged;
   logic            tx_data_ready;
   logic [7:0]      tx_data_out;
   logic            tx_data_eom, tx_data_broadcast;

   logic [7:0] mem [2][16];

   exp_byte_t exp_q [$];
   outcome_t  out_q [$];

   int n_pass = 0;
   int n_total = 0;
   int free_cnt = 0;
   int ptr_m = 0;
   bit last_ours_m = 0;
   int nack_byte = 0;
   int nack_left = 0;
   int pos = 0;

   always #5 clk = ~clk;

   assign req_rd_data[0] = mem[0][rd_idx];
   assign req_rd_data[1] = mem[1][rd_idx];

   cec_frame_scheduler #(
      .LOGICAL_ADDR (4'h4),
      .BIT_CYCLES   (BITC),
      .MAX_RETRY    (MAX_RETRY)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_dest             (req_dest),
      .req_len              (req_len),
      .rd_idx               (rd_idx),
      .req_rd_data          (req_rd_data),
      .done                 (done),
      .fail                 (fail),
      .busy                 (busy),
      .cec_line             (cec_line),
      .tx_idle              (tx_idle),
      .tx_byte_acknowledged (tx_byte_acknowledged),
      .tx_data_ready        (tx_data_ready),
      .tx_data_out          (tx_data_out),
      .tx_data_eom          (tx_data_eom),
      .tx_data_broadcast    (tx_data_broadcast)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One clock: the free-time model tracks the bus exactly like the DUT counter (without saturation).
   task automatic step();
      @(posedge clk);
      if (cec_line) free_cnt++;
      else free_cnt = 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      tx_idle = 1'b1;
      cec_line = 1'b1;
      tx_byte_acknowledged = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      free_cnt = 1000000;
      ptr_m = 0;
      last_ours_m = 0;
      pos = 0;
   endtask

   function automatic exp_byte_t mk_byte(input int w, input int k, input logic [3:0] dest,
                                         input logic [3:0] len, input int minf);
      exp_byte_t e;
      e.data     = (k == 0) ? {4'h4, dest} : mem[w][k-1];
      e.eom      = (k == int'(len));
      e.bcast    = (dest == 4'hF);
      e.hdr      = (k == 0);
      e.min_free = minf;
      return e;
   endfunction

   // Model of arbitration, retry count and free-time rules; fills the scoreboard for one frame.
   task automatic plan(input int nbyte, input int nacks);
      int w, nfail, limit, minf;
      bit ok;
      outcome_t o;
      w = req_valid[ptr_m] ? ptr_m : 1 - ptr_m;
`ifdef CEC_RETRY_EN
      limit = MAX_RETRY + 1;
`else
      limit = 1;
`endif
      nfail = (nacks > limit) ? limit : nacks;
      ok = (nfail < limit);
      for (int a = 0; a <= nfail; a++) begin
         if (a < nfail || ok) begin
            minf = (a == 0) ? (last_ours_m ? 7 * BITC : 5 * BITC) : 3 * BITC;
            for (int k = 0; k <= ((a < nfail) ? nbyte : int'(req_len[w])); k++)
               exp_q.push_back(mk_byte(w, k, req_dest[w], req_len[w], minf));
         end
      end
      o.rq = w;
      o.ok = ok;
      out_q.push_back(o);
      last_ours_m = ok;
      ptr_m = 1 - w;
   endtask

   // Behavioural byte transmitter: accepts the ready pulse, drives the line, acks per plan.
   task automatic transmit();
      exp_byte_t e;
      bit ack;
      e = '{data: 8'h00, eom: 1'b0, bcast: 1'b0, hdr: 1'b0, min_free: 0};
      if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data_out), 32'hFFFF_FFFF);
      else e = exp_q.pop_front();
      check("tx_data", 32'(tx_data_out), 32'(e.data));
      check("tx_eom", 32'(tx_data_eom), 32'(e.eom));
      check("tx_bcast", 32'(tx_data_broadcast), 32'(e.bcast));
      if (e.hdr) check("free_time", 32'(free_cnt >= e.min_free), 32'd1);
      ack = !(pos == nack_byte && nack_left > 0);
      step();
      check("ready_pulse", 32'(tx_data_ready), 32'd0);
      tx_idle = 1'b0;
      cec_line = 1'b0;
      repeat (20) step();
      check("tx_hold", 32'({tx_data_out, tx_data_eom}), 32'({e.data, e.eom}));
      cec_line = 1'b1;
      step();
      tx_byte_acknowledged = ack;
      step();
      tx_byte_acknowledged = 1'b0;
      repeat (3) step();
      tx_idle = 1'b1;
      if (!ack) begin
         nack_left--;
         pos = 0;
      end else if (e.eom) pos = 0;
      else pos++;
   endtask

   task automatic serve(output int who, output bit was_done);
      who = -1;
      was_done = 0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         step();
         if (done != 2'b00 || fail != 2'b00) begin
            who = (done[1] | fail[1]) ? 1 : 0;
            was_done = |done;
            return;
         end
         if (tx_data_ready) transmit();
      end
      check("serve_timeout", 32'd1, 32'd0);
   endtask

   task automatic finish_frame(input int who, input bit was_done);
      outcome_t o;
      o = out_q.pop_front();
      check("winner", 32'(who), 32'(o.rq));
      check("outcome_done", 32'(was_done), 32'(o.ok));
      check("attempt_bytes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      step();
      check("pulse_width", 32'({done, fail}), 32'd0);
   endtask

   task automatic run_vec(input frame_vec_t v);
      int who;
      bit wd;
      req_dest[v.rq] = v.dest;
      req_len[v.rq] = v.len;
      req_valid[v.rq] = 1'b1;
      nack_byte = v.nack_byte;
      nack_left = v.nacks;
      pos = 0;
      plan(v.nack_byte, v.nacks);
      serve(who, wd);
      req_valid[v.rq] = 1'b0;
      finish_frame(who, wd);
   endtask

   frame_vec_t vecs [5];

   initial begin
      int who;
      bit wd, early;
      vecs[0] = '{rq: 0, dest: 4'h0, len: 4'd2,  nack_byte: 0, nacks: 0};
      vecs[1] = '{rq: 1, dest: 4'hF, len: 4'd0,  nack_byte: 0, nacks: 0};
      vecs[2] = '{rq: 0, dest: 4'h3, len: 4'd3,  nack_byte: 1, nacks: 2};
      vecs[3] = '{rq: 1, dest: 4'h2, len: 4'd1,  nack_byte: 0, nacks: 99};
      vecs[4] = '{rq: 1, dest: 4'h7, len: 4'd15, nack_byte: 0, nacks: 0};
      for (int i = 0; i < 16; i++) begin
         mem[0][i] = 8'h44 + 8'(i * 17);
         mem[1][i] = 8'hA0 ^ 8'(i);
      end
      req_dest = '0;
      req_len = '0;

      do_reset();
      check("reset_outputs", 32'({done, fail, busy, tx_data_ready, tx_data_out, tx_data_eom,
                                  tx_data_broadcast, rd_idx}), 32'd0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Both requesters pending from reset: pointer 0 first, then alternate.
      do_reset();
      req_dest = {4'h2, 4'h1};
      req_len = {4'd1, 4'd1};
      req_valid = 2'b11;
      nack_left = 0;
      for (int i = 0; i < 3; i++) begin
         pos = 0;
         plan(0, 0);
         serve(who, wd);
         finish_frame(who, wd);
      end
      req_valid = 2'b00;
      step();

      // Bus activity during WAIT_FREE restarts the free-time count.
      req_dest[0] = 4'h5;
      req_len[0] = 4'd0;
      req_valid[0] = 1'b1;
      pos = 0;
      plan(0, 0);
      early = 0;
      repeat (200) begin
         step();
         if (tx_data_ready) early = 1;
      end
      check("no_early_issue", 32'(early), 32'd0);
      cec_line = 1'b0;
      repeat (5) step();
      cec_line = 1'b1;
      serve(who, wd);
      req_valid[0] = 1'b0;
      finish_frame(who, wd);

      // Reset while a byte is on the wire.
      req_dest[1] = 4'h6;
      req_len[1] = 4'd2;
      req_valid[1] = 1'b1;
      early = 1;
      for (int cyc = 0; cyc < 2000 && early; cyc++) begin
         step();
         if (tx_data_ready) early = 0;
      end
      check("reset_test_ready", 32'(early), 32'd0);
      check("reset_test_hdr", 32'(tx_data_out), 32'h46);
      step();
      tx_idle = 1'b0;
      cec_line = 1'b0;
      repeat (5) step();
      cec_line = 1'b1;
      repeat (2) step();
      check("busy_before_reset", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check("reset_mid_frame", 32'({done, fail, busy, tx_data_ready, tx_data_out, tx_data_eom,
                                    tx_data_broadcast, rd_idx}), 32'd0);
      rst = 1'b0;
      tx_idle = 1'b1;
      req_valid = 2'b00;
      early = 0;
      repeat (20) begin
         step();
         if (done != 2'b00 || fail != 2'b00) early = 1;
      end
      check("no_pulse_after_reset", 32'(early), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
